// File: rtl/mdu_seq_if.sv
// Request/response bundle between the EX stage (master) and the iterative MDU sequencer (slave).
// a/b/c are MSB-first words: the most significant bit is the sign bit.
interface mdu_seq_if #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3
);
   logic             start;
   logic             flush;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] c;
   logic [3:0]       d;

   modport master (output start, flush, op, a, b, input busy, done, c, d);
   modport slave  (input start, flush, op, a, b, output busy, done, c, d);
endinterface

// File: rtl/mdu_seq_ctrl.sv
// Iterative radix-2 multiply / restoring-divide sequencer: IDLE -> LOAD -> RUN -> FIX -> DONE.
// Op codes: 0 MULH, 1 MULHU, 2 MULW, 3 DIVW, 4 DIVWU. Optional: MDU_DIV_EXCEPT_EN (divide exception fast path).
module mdu_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6,
   parameter int OP_W  = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   mdu_seq_if.slave bus
);
   localparam logic [OP_W-1:0] OP_MULH  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_MULHU = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MULW  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_DIVW  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_DIVWU = OP_W'(4);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0]    op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   c_q, c_d;
   logic [3:0]         dv_q, dv_d;

   logic               op_div, op_signed, op_known;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   res;
   logic               ov;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg2(input logic [2*WIDTH-1:0] v);
      return -v;
   endfunction

   function automatic logic [2:0] sign_flags(input logic signed [WIDTH-1:0] v);
      return {v[WIDTH-1], !v[WIDTH-1] && (v != '0), v == '0};
   endfunction

   assign op_div    = (op_q == OP_DIVW) || (op_q == OP_DIVWU);
   assign op_signed = (op_q == OP_MULH) || (op_q == OP_MULW) || (op_q == OP_DIVW);
   assign op_known  = (op_q <= OP_DIVWU);

`ifdef MDU_DIV_EXCEPT_EN
   logic div_exc;
   assign div_exc = op_div && ((opb_q == '0) ||
                    ((op_q == OP_DIVW) && (opa_q == {1'b1, {(WIDTH-1){1'b0}}}) && (opb_q == '1)));
`endif

   assign bus.busy = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FIX);
   assign bus.done = (state_q == S_DONE);
   assign bus.c    = c_q;
   assign bus.d    = dv_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      c_d     = c_q;
      dv_d    = dv_q;
      res     = '0;
      ov      = 1'b0;

      // hi:lo is the product accumulator, or remainder:quotient for divides
      mul_sum   = {1'b0, hi_q} + {1'b0, opb_q & {WIDTH{lo_q[0]}}};
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      prod      = neg_q ? neg2({hi_q, lo_q}) : {hi_q, lo_q};
      quot      = neg_q ? -lo_q : lo_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               opa_d   = bus.a;
               opb_d   = bus.b;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d = '0;
            if (!op_known) begin
               c_d     = '0;
               dv_d    = 4'b0001;
               state_d = S_DONE;
`ifdef MDU_DIV_EXCEPT_EN
            end else if (div_exc) begin
               c_d     = '0;
               dv_d    = 4'b1001;
               state_d = S_DONE;
`endif
            end else begin
               neg_d   = op_signed && (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
               hi_d    = '0;
               // opb holds the divisor or the multiplicand; lo holds dividend or multiplier
               lo_d    = op_div ? (op_signed ? mag(opa_q) : opa_q) : (op_signed ? mag(opb_q) : opb_q);
               opb_d   = op_div ? (op_signed ? mag(opb_q) : opb_q) : (op_signed ? mag(opa_q) : opa_q);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (op_div) begin
               hi_d = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], div_ge};
            end else begin
               hi_d = mul_sum[WIDTH:1];
               lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            case (op_q)
               OP_MULH, OP_MULHU: res = prod[2*WIDTH-1:WIDTH];
               OP_MULW: begin
                  res = prod[WIDTH-1:0];
                  ov  = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
               end
               default: res = quot;
            endcase
            c_d     = res;
            dv_d    = {ov, sign_flags(res)};
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A pipeline kill abandons the op without touching the visible result
      if (bus.flush) begin
         state_d = S_IDLE;
         c_d     = c_q;
         dv_d    = dv_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         c_q     <= '0;
         dv_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         dv_q    <= dv_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q  <= op_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      neg_q <= neg_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
   end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: arithmetic reference model, per-cycle compare, directed vectors.
module tb_mdu_seq_ctrl;
   localparam int W = 32;
   localparam logic [2:0] MULH = 3'd0, MULHU = 3'd1, MULW = 3'd2, DIVW = 3'd3, DIVWU = 3'd4, BADOP = 3'd7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mdu_seq_if #(.WIDTH(W), .OP_W(3)) bus();

   mdu_seq_ctrl #(.WIDTH(W), .CNT_W(6), .OP_W(3)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: result, flags and latency straight from the arithmetic definition of each op
   function automatic void expect_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] c, output logic [3:0] d, output int lat);
      logic [63:0] p;
      logic        ov;
      lat = 35;
      ov  = 1'b0;
      c   = '0;
      p   = '0;
      case (op)
         MULH: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            c = p[63:32];
         end
         MULHU: begin
            p = {32'b0, a} * {32'b0, b};
            c = p[63:32];
         end
         MULW: begin
            p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            c  = p[31:0];
            ov = (p[63:32] != {32{p[31]}});
         end
         DIVW: begin
            if (b == 0)                                     c = a[31] ? 32'h1 : 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) c = 32'h80000000;
            else                                            c = $signed(a) / $signed(b);
`ifdef MDU_DIV_EXCEPT_EN
            if (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) begin
               c = 0; ov = 1'b1; lat = 2;
            end
`endif
         end
         DIVWU: begin
            c = (b == 0) ? 32'hFFFFFFFF : a / b;
`ifdef MDU_DIV_EXCEPT_EN
            if (b == 0) begin c = 0; ov = 1'b1; lat = 2; end
`endif
         end
         default: begin
            c = 0; lat = 2;
         end
      endcase
      d = {ov, c[31], !c[31] && (c != 0), c == 0};
   endfunction

   // Model timeline: m_age is the cycle index since acceptance (-1 when idle)
   int          m_age = -1;
   int          m_lat = 35;
   logic [31:0] m_c = '0, m_pc = '0;
   logic [3:0]  m_d = '0, m_pd = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_age = -1; m_c = '0; m_d = '0;
      end else if (bus.flush) begin
         m_age = -1;
      end else if (m_age < 0) begin
         if (bus.start) begin
            expect_of(bus.op, bus.a, bus.b, m_pc, m_pd, m_lat);
            m_age = 1;
         end
      end else if (m_age == m_lat) begin
         m_age = -1;
      end else begin
         m_age++;
         if (m_age == m_lat) begin m_c = m_pc; m_d = m_pd; end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy_done", {bus.busy, bus.done}, {(m_age >= 1) && (m_age < m_lat), m_age == m_lat});
         chk("c_d", {bus.c, bus.d}, {m_c, m_d});
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ec, input logic [3:0] ed, input int elat, input string name);
      int n;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         bus.start = 1'b0;
      end while (!bus.done && n < 100);
      chk({name, "_lat"}, n, elat);
      chk({name, "_c"}, bus.c, ec);
      chk({name, "_d"}, bus.d, ed);
      @(posedge clk); #1;
   endtask

   logic [31:0] pc;
   logic [3:0]  pd;
   int          pl;
   int          done_at[$];

   initial begin
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

      expect_of(MULW, 32'h7, 32'hFFFFFFFD, pc, pd, pl);
      chk("model_mulw", {pc, pd, 8'(pl)}, {32'hFFFFFFEB, 4'b0100, 8'd35});
      expect_of(DIVW, 32'hFFFFFF9C, 32'h7, pc, pd, pl);
      chk("model_divw", {pc, pd}, {32'hFFFFFFF2, 4'b0100});
      expect_of(MULH, 32'h40000000, 32'h4, pc, pd, pl);
      chk("model_mulh", {pc, pd}, {32'h1, 4'b0010});

      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {bus.busy, bus.done, bus.c, bus.d}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(MULW,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0100, 35, "mulw_neg");
      run_op(MULH,  32'h40000000, 32'h00000004, 32'h00000001, 4'b0010, 35, "mulh");
      run_op(MULW,  32'h40000000, 32'h00000004, 32'h00000000, 4'b1001, 35, "mulw_ov");
      run_op(DIVWU, 32'h00000064, 32'h00000007, 32'h0000000E, 4'b0010, 35, "divwu");
      run_op(DIVW,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 4'b0100, 35, "divw_neg");
      run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 35, "mulhu");
      run_op(MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 35, "mulh_m1");
      run_op(BADOP, 32'h12345678, 32'h9, 32'h00000000, 4'b0001, 2, "badop");
`ifdef MDU_DIV_EXCEPT_EN
      run_op(DIVWU, 32'h5, 32'h0, 32'h0, 4'b1001, 2, "divwu_b0");
      run_op(DIVW,  32'h80000000, 32'hFFFFFFFF, 32'h0, 4'b1001, 2, "divw_ovf");
      run_op(DIVW,  32'hFFFFFFF9, 32'h0, 32'h0, 4'b1001, 2, "divw_b0");
`else
      run_op(DIVWU, 32'h5, 32'h0, 32'hFFFFFFFF, 4'b0100, 35, "divwu_b0");
      run_op(DIVW,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 35, "divw_ovf");
      run_op(DIVW,  32'hFFFFFFF9, 32'h0, 32'h00000001, 4'b0010, 35, "divw_b0");
`endif

      // start held high: accepted every 36 cycles, operand change mid-run only affects the next op
      bus.start = 1'b1; bus.op = MULW; bus.a = 32'h3; bus.b = 32'h5;
      for (int k = 1; k <= 110; k++) begin
         @(posedge clk); #1;
         if (k == 10) bus.a = 32'h9;
         if (k == 100) bus.start = 1'b0;
         if (bus.done) done_at.push_back(k);
      end
      chk("hold_ndone", done_at.size(), 3);
      if (done_at.size() == 3) begin
         chk("hold_first", done_at[0], 35);
         chk("hold_gap1", done_at[1] - done_at[0], 36);
         chk("hold_gap2", done_at[2] - done_at[1], 36);
      end
      chk("hold_last_c", {bus.c, bus.d}, {32'h2D, 4'b0010});

      // flush at RUN counter 10
      bus.start = 1'b1; bus.op = DIVWU; bus.a = 32'd1000; bus.b = 32'd3;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (k == 12) bus.flush = 1'b1;
      end
      bus.flush = 1'b0;
      chk("flush_idle", {bus.busy, bus.done, bus.c, bus.d}, {2'b00, 32'h2D, 4'b0010});
      run_op(DIVWU, 32'd1000, 32'd3, 32'd333, 4'b0010, 35, "after_flush");

      // flush and start together in IDLE: op not accepted
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = MULW; bus.a = 32'h2; bus.b = 32'h2;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_start", {bus.busy, bus.done}, 2'b00);
      @(posedge clk); #1;
      chk("flush_start2", {bus.busy, bus.done}, 2'b00);

      // asynchronous reset in the middle of an op
      bus.start = 1'b1; bus.op = MULHU; bus.a = 32'hFFFF0000; bus.b = 32'h00010000;
      repeat (6) begin @(posedge clk); #1; bus.start = 1'b0; end
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset", {bus.busy, bus.done, bus.c, bus.d}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(MULHU, 32'hFFFF0000, 32'h00010000, 32'h0000FFFF, 4'b0010, 35, "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
